// File: rtl/sdr_tg_pkg.sv
// Shared constants for the SDRAM traffic checker: FSM states, mode encodings, LFSR taps.
package sdr_tg_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_WAIT_INIT = 3'd1;
  localparam logic [STATE_W-1:0] S_WR_CMD    = 3'd2;
  localparam logic [STATE_W-1:0] S_WR_DATA   = 3'd3;
  localparam logic [STATE_W-1:0] S_RD_CMD    = 3'd4;
  localparam logic [STATE_W-1:0] S_RD_DATA   = 3'd5;
  localparam logic [STATE_W-1:0] S_DONE      = 3'd6;

  localparam logic [1:0] AM_SEQ    = 2'd0;
  localparam logic [1:0] AM_LFSR   = 2'd1;
  localparam logic [1:0] AM_HAMMER = 2'd2;

  localparam logic [1:0] DM_ADDR_XOR = 2'd0;
  localparam logic [1:0] DM_WALK1    = 2'd1;
  localparam logic [1:0] DM_INV_ADDR = 2'd2;

  // Right-shifting Galois feedback masks giving a maximal-length sequence per width
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      17:      lfsr_taps = 32'h0001_2000;
      18:      lfsr_taps = 32'h0002_0400;
      19:      lfsr_taps = 32'h0004_0023;
      20:      lfsr_taps = 32'h0009_0000;
      21:      lfsr_taps = 32'h0014_0000;
      22:      lfsr_taps = 32'h0030_0000;
      23:      lfsr_taps = 32'h0042_0000;
      24:      lfsr_taps = 32'h00E1_0000;
      25:      lfsr_taps = 32'h0120_0000;
      26:      lfsr_taps = 32'h0200_0023;
      27:      lfsr_taps = 32'h0400_0013;
      28:      lfsr_taps = 32'h0900_0000;
      29:      lfsr_taps = 32'h1400_0000;
      30:      lfsr_taps = 32'h2000_0029;
      31:      lfsr_taps = 32'h4800_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_0001;
    endcase
  endfunction

endpackage

// File: rtl/sdr_tg_patgen.sv
// Address generator (sequential / LFSR / hammer) and per-beat data pattern mapper.
module sdr_tg_patgen
  import sdr_tg_pkg::*;
#(
  parameter int unsigned AW        = 21,
  parameter int unsigned DQ_W      = 32,
  parameter int unsigned BURST_LEN = 1,
  parameter int unsigned BEAT_W    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [1:0]        addr_mode_i,
  input  logic [1:0]        data_mode_i,
  input  logic [DQ_W-1:0]   seed_i,
  input  logic [AW-1:0]     base_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic [AW-1:0]     addr_o,
  output logic [AW-1:0]     beat_addr_o,
  output logic [DQ_W-1:0]   data_o
);

  localparam int unsigned OFF_W  = $clog2(BURST_LEN);
  localparam int unsigned LFSR_W = AW - OFF_W;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [AW-1:0]     addr_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] seed_lfsr;

  assign seed_lfsr = LFSR_W'(seed_i);

  // Load from base/seed at the start of each phase; advance once per completed command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      lfsr_q <= LFSR_W'(1);
    end else if (load_i) begin
      addr_q <= base_i;
      lfsr_q <= (seed_lfsr == '0) ? LFSR_W'(1) : seed_lfsr;
    end else if (step_i) begin
      if (addr_mode_i == AM_SEQ) begin
        addr_q <= addr_q + AW'(BURST_LEN);
      end
      if (addr_mode_i == AM_LFSR) begin
        lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
      end
    end
  end

  // LFSR occupies the upper bits so every command stays burst-aligned
  assign addr_o      = (addr_mode_i == AM_LFSR) ? (AW'(lfsr_q) << OFF_W) : addr_q;
  assign beat_addr_o = addr_o + AW'(beat_i);

  // Data word for the address of the current beat
  always_comb begin
    data_o = DQ_W'(beat_addr_o) ^ seed_i;
    case (data_mode_i)
      DM_WALK1:    data_o = DQ_W'(1) << (beat_addr_o % AW'(DQ_W));
      DM_INV_ADDR: data_o = ~DQ_W'(beat_addr_o);
      default:     data_o = DQ_W'(beat_addr_o) ^ seed_i;
    endcase
  end

endmodule

// File: rtl/sdram_traffic_checker.sv
// Built-in SDRAM memory test: writes a region with a pattern, reads it back and checks it.
module sdram_traffic_checker
  import sdr_tg_pkg::*;
#(
  parameter int unsigned BA_W      = 2,
  parameter int unsigned ROW_W     = 11,
  parameter int unsigned COL_W     = 8,
  parameter int unsigned DQ_W      = 32,
  parameter int unsigned BURST_LEN = 1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  addr_mode,
  input  logic [1:0]                  data_mode,
  input  logic [DQ_W-1:0]             seed,
  input  logic [BA_W+ROW_W+COL_W-1:0] base_addr,
  input  logic [CNT_W-1:0]            num_cmds,
  input  logic                        init_done,
  output logic                        cmd,
  output logic                        cmd_valid,
  output logic [BA_W-1:0]             bankAddr,
  output logic [ROW_W-1:0]            rowAddr,
  output logic [COL_W-1:0]            colAddr,
  output logic [DQ_W/8-1:0]           data_mask,
  input  logic                        cmd_rdy,
  input  logic                        data_rdy,
  output logic [DQ_W-1:0]             write_data,
  input  logic [DQ_W-1:0]             read_data,
  input  logic                        read_data_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        timeout,
  output logic [CNT_W-1:0]            err_count,
  output logic [BA_W+ROW_W+COL_W-1:0] first_err_addr
);

  localparam int unsigned AW     = BA_W + ROW_W + COL_W;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [1:0]      addr_mode_q, data_mode_q;
  logic [DQ_W-1:0] seed_q;
  logic [AW-1:0]   base_q;
  logic [CNT_W-1:0] num_q;

  logic             cmd_q, cmd_valid_q, busy_q, done_q, error_q, timeout_q;
  logic             cmd_d, cmd_valid_d, busy_d, done_d, error_d, timeout_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [AW-1:0]    first_err_q, first_err_d;

  logic            start_ok, gen_load, gen_step, waiting, tmo_hit, beat_ev, mismatch;
  logic            last_beat, last_cmd;
  logic [AW-1:0]   gen_addr, gen_beat_addr;
  logic [DQ_W-1:0] gen_data;

  sdr_tg_patgen #(
    .AW        (AW),
    .DQ_W      (DQ_W),
    .BURST_LEN (BURST_LEN),
    .BEAT_W    (BEAT_W)
  ) u_patgen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (gen_load),
    .step_i      (gen_step),
    .addr_mode_i (addr_mode_q),
    .data_mode_i (data_mode_q),
    .seed_i      (seed_q),
    .base_i      (base_q),
    .beat_i      (beat_q),
    .addr_o      (gen_addr),
    .beat_addr_o (gen_beat_addr),
    .data_o      (gen_data)
  );

  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign last_cmd  = (cmd_cnt_q == num_q - CNT_W'(1));
  assign mismatch  = (state_q == S_RD_DATA) && read_data_valid && (read_data != gen_data);

  // Next-state, counters, generator control and status updates
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cmd_cnt_d   = cmd_cnt_q;
    tmo_d       = tmo_q;
    gen_load    = 1'b0;
    gen_step    = 1'b0;
    waiting     = 1'b0;
    tmo_hit     = 1'b0;
    beat_ev     = 1'b0;
    error_d     = error_q;
    timeout_d   = timeout_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = (num_cmds == '0) ? S_DONE : S_WAIT_INIT;
        end
      end
      S_WAIT_INIT: begin
        if (init_done) begin
          state_d   = S_WR_CMD;
          gen_load  = 1'b1;
          cmd_cnt_d = '0;
          beat_d    = '0;
          tmo_d     = '0;
        end
      end
      S_WR_CMD, S_RD_CMD: begin
        if (cmd_rdy) begin
          tmo_d   = '0;
          beat_d  = '0;
          state_d = (state_q == S_WR_CMD) ? S_WR_DATA : S_RD_DATA;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WR_DATA, S_RD_DATA: begin
        beat_ev = (state_q == S_WR_DATA) ? data_rdy : read_data_valid;
        if (beat_ev) begin
          tmo_d = '0;
          if (last_beat) begin
            beat_d   = '0;
            gen_step = 1'b1;
            if (last_cmd) begin
              cmd_cnt_d = '0;
              if (state_q == S_WR_DATA) begin
                state_d  = S_RD_CMD;
                gen_load = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
              state_d   = (state_q == S_WR_DATA) ? S_WR_CMD : S_RD_CMD;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          waiting = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any stalled handshake or beat is bounded by the timeout counter
    if (waiting) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        tmo_hit = 1'b1;
        state_d = S_DONE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (start_ok) begin
      error_d     = 1'b0;
      timeout_d   = 1'b0;
      err_count_d = '0;
      first_err_d = '0;
    end
    if (mismatch) begin
      error_d = 1'b1;
      if (err_count_q != '1) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
      if (err_count_q == '0) begin
        first_err_d = gen_beat_addr;
      end
    end
    if (tmo_hit) begin
      error_d   = 1'b1;
      timeout_d = 1'b1;
    end

    cmd_valid_d = (state_d == S_WR_CMD) || (state_d == S_RD_CMD);
    cmd_d       = (state_d == S_RD_CMD) || (state_d == S_RD_DATA);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // FSM state and sequencing counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      cmd_cnt_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cmd_cnt_q <= cmd_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  // Test configuration captured on an accepted start so it is stable for the whole run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_mode_q <= AM_SEQ;
      data_mode_q <= DM_ADDR_XOR;
      seed_q      <= '0;
      base_q      <= '0;
      num_q       <= '0;
    end else if (start_ok) begin
      addr_mode_q <= addr_mode;
      data_mode_q <= data_mode;
      seed_q      <= seed;
      base_q      <= base_addr;
      num_q       <= num_cmds;
    end
  end

  // Registered command and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign cmd            = cmd_q;
  assign cmd_valid      = cmd_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;
  assign bankAddr       = gen_addr[AW-1 -: BA_W];
  assign rowAddr        = gen_addr[COL_W +: ROW_W];
  assign colAddr        = gen_addr[COL_W-1:0];
  assign data_mask      = '0;
  assign write_data     = (state_q == S_WR_DATA) ? gen_data : '0;

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// Randomised bench: acts as the SDRAM controller plus memory and checks against a behavioural model.
module tb_sdram_traffic_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, init_done, cmd_rdy, data_rdy, read_data_valid;
  logic [1:0]  addr_mode, data_mode;
  logic [31:0] seed, read_data;
  logic [20:0] base;
  logic [15:0] num_cmds;

  logic        a_cmd, a_cv, a_busy, a_done, a_err, a_tmo;
  logic [1:0]  a_bank;
  logic [10:0] a_row;
  logic [7:0]  a_col;
  logic [3:0]  a_dm;
  logic [31:0] a_wd;
  logic [15:0] a_ec;
  logic [20:0] a_fea;

  logic        b_cmd, b_cv, b_busy, b_done, b_err, b_tmo;
  logic [0:0]  b_bank, b_row;
  logic [7:0]  b_col;
  logic [3:0]  b_dm;
  logic [31:0] b_wd;
  logic [15:0] b_ec;
  logic [9:0]  b_fea;

  sdram_traffic_checker #(.BA_W(2), .ROW_W(11), .COL_W(8), .DQ_W(32), .BURST_LEN(1),
                          .CNT_W(16), .TIMEOUT(255)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .addr_mode(addr_mode), .data_mode(data_mode),
    .seed(seed), .base_addr(base), .num_cmds(num_cmds), .init_done(init_done),
    .cmd(a_cmd), .cmd_valid(a_cv), .bankAddr(a_bank), .rowAddr(a_row), .colAddr(a_col),
    .data_mask(a_dm), .cmd_rdy(cmd_rdy), .data_rdy(data_rdy), .write_data(a_wd),
    .read_data(read_data), .read_data_valid(read_data_valid), .busy(a_busy), .done(a_done),
    .error(a_err), .timeout(a_tmo), .err_count(a_ec), .first_err_addr(a_fea));

  // Small address space so a 4-beat burst can wrap past the top
  sdram_traffic_checker #(.BA_W(1), .ROW_W(1), .COL_W(8), .DQ_W(32), .BURST_LEN(4),
                          .CNT_W(16), .TIMEOUT(255)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .addr_mode(addr_mode), .data_mode(data_mode),
    .seed(seed), .base_addr(base[9:0]), .num_cmds(num_cmds), .init_done(init_done),
    .cmd(b_cmd), .cmd_valid(b_cv), .bankAddr(b_bank), .rowAddr(b_row), .colAddr(b_col),
    .data_mask(b_dm), .cmd_rdy(cmd_rdy), .data_rdy(data_rdy), .write_data(b_wd),
    .read_data(read_data), .read_data_valid(read_data_valid), .busy(b_busy), .done(b_done),
    .error(b_err), .timeout(b_tmo), .err_count(b_ec), .first_err_addr(b_fea));

  logic        sel;
  logic        o_cmd, o_cv, o_busy, o_done, o_err, o_tmo;
  logic [20:0] o_addr, o_fea;
  logic [31:0] o_wd;
  logic [15:0] o_ec;
  logic [3:0]  o_dm;

  always_comb begin
    if (sel) begin
      o_cmd = b_cmd; o_cv = b_cv; o_busy = b_busy; o_done = b_done; o_err = b_err; o_tmo = b_tmo;
      o_addr = {11'b0, b_bank, b_row, b_col}; o_fea = {11'b0, b_fea};
      o_wd = b_wd; o_ec = b_ec; o_dm = b_dm;
    end else begin
      o_cmd = a_cmd; o_cv = a_cv; o_busy = a_busy; o_done = a_done; o_err = a_err; o_tmo = a_tmo;
      o_addr = {a_bank, a_row, a_col}; o_fea = a_fea;
      o_wd = a_wd; o_ec = a_ec; o_dm = a_dm;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mem [int];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference data pattern for a flat address
  function automatic logic [31:0] pat(input logic [20:0] a, input logic [1:0] dm, input logic [31:0] sd);
    logic [31:0] ax;
    ax = {11'b0, a};
    case (dm)
      2'd1:    return 32'h1 << (ax % 32);
      2'd2:    return ~ax;
      default: return ax ^ sd;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cv"},   o_cv,   0);
    check_eq({tag, "_cmd"},  o_cmd,  0);
    check_eq({tag, "_addr"}, o_addr, 0);
    check_eq({tag, "_wd"},   o_wd,   0);
    check_eq({tag, "_stat"}, {o_busy, o_done, o_err, o_tmo}, 0);
    check_eq({tag, "_ec"},   o_ec,   0);
    check_eq({tag, "_fea"},  o_fea,  0);
  endtask

  task automatic run(input logic s, input logic [1:0] am, input logic [1:0] dm,
                     input logic [31:0] sd, input logic [20:0] b, input int n, input int corrupt,
                     input bit withhold, input bit busy_start, input bit rst_mid);
    logic [20:0] mask, cur, a, first_lfsr, exp_fea;
    logic [31:0] d;
    logic [20:0] wq[$];
    bit          seen[int];
    int bl, lw, off, cb, nwr, nrd, nrb, exp_ec, vcnt;
    bit pend, is_rd, just_acked, finished, aborted;

    mask = s ? 21'h3FF : 21'h1F_FFFF;
    bl   = s ? 4 : 1;
    lw   = s ? 8 : 21;
    off  = s ? 2 : 0;
    first_lfsr = 21'(sd & ((32'h1 << lw) - 1));
    if (first_lfsr == 0) first_lfsr = 21'h1;
    first_lfsr = first_lfsr << off;
    mem.delete();
    nwr = 0; nrd = 0; nrb = 0; exp_ec = 0; vcnt = 0; cb = 0; exp_fea = '0; cur = '0;
    pend = 0; is_rd = 0; just_acked = 0; finished = 0; aborted = 0;

    sel = s; addr_mode = am; data_mode = dm; seed = sd; base = b; num_cmds = 16'(n);
    @(posedge clk); #1;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      cmd_rdy = 0; data_rdy = 0; read_data_valid = 0; read_data = '0; start_a = 0; start_b = 0;
      if (o_done) begin
        finished = 1;
      end else begin
        if (o_cv) vcnt++;
        if (busy_start && cyc == 30) begin
          if (s) start_b = 1'b1; else start_a = 1'b1;
        end
        if (just_acked) begin
          check_eq("cv_drop", o_cv, 0);
          just_acked = 0;
        end
        if (pend && !is_rd) begin
          if ($urandom_range(3) != 0) begin
            data_rdy = 1;
            a = (cur + 21'(cb)) & mask;
            check_eq("wdata", o_wd, pat(a, dm, sd));
            mem[int'(a)] = o_wd;
            cb++;
            if (cb == bl) pend = 0;
          end
        end else if (pend && is_rd) begin
          if (rst_mid && nrd >= 2) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("rst_mid");
            aborted = 1;
            break;
          end
          if ($urandom_range(3) != 0) begin
            read_data_valid = 1;
            a = (cur + 21'(cb)) & mask;
            d = mem.exists(int'(a)) ? mem[int'(a)] : 32'hDEAD_BEEF;
            if (int'(a) == corrupt) d = d ^ 32'h8;
            read_data = d;
            if (d != pat(a, dm, sd)) begin
              if (exp_ec == 0) exp_fea = a;
              exp_ec++;
            end
            nrb++;
            cb++;
            if (cb == bl) pend = 0;
          end
        end else if (o_cv && !withhold && $urandom_range(1) == 1) begin
          cmd_rdy = 1; cur = o_addr; cb = 0; pend = 1; is_rd = o_cmd; just_acked = 1;
          if (!o_cmd) begin
            if (am == 2'd1) begin
              if (nwr == 0) check_eq("lfsr_first", cur, first_lfsr);
              else          check_eq("lfsr_unique", seen.exists(int'(cur)), 0);
              seen[int'(cur)] = 1'b1;
            end else if (am == 2'd2) begin
              check_eq("hammer_addr", cur, b & mask);
            end else begin
              check_eq("seq_addr", cur, (b + 21'(nwr * bl)) & mask);
            end
            wq.push_back(cur);
            nwr++;
          end else begin
            if (wq.size() == 0) check_eq("rd_extra", 1, 0);
            else                check_eq("rd_addr", cur, wq.pop_front());
            nrd++;
          end
        end else if ($urandom_range(3) == 0) begin
          read_data_valid = 1;
          read_data = $urandom;
        end
      end
      if (!finished) begin
        @(posedge clk); #1;
      end
    end

    cmd_rdy = 0; data_rdy = 0; read_data_valid = 0; start_a = 0; start_b = 0;
    if (!aborted) begin
      check_eq("run_bound", finished, 1);
      check_eq("done", o_done, 1);
      check_eq("busy", o_busy, 0);
      check_eq("timeout", o_tmo, withhold);
      if (withhold) begin
        check_eq("cv_after_tmo", o_cv, 0);
        check_eq("cv_cycles", vcnt, 255);
        check_eq("n_wr_tmo", nwr, 0);
      end else begin
        check_eq("n_wr", nwr, n);
        check_eq("n_rd", nrd, n);
        check_eq("n_beats", nrb, n * bl);
      end
      check_eq("err_count", o_ec, exp_ec);
      check_eq("error", o_err, (exp_ec > 0) || withhold);
      check_eq("first_err", o_fea, (exp_ec > 0) ? exp_fea : 21'h0);
      check_eq("dmask", o_dm, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] rb;
    rst_n = 0; start_a = 0; start_b = 0; init_done = 1; cmd_rdy = 0; data_rdy = 0;
    read_data_valid = 0; read_data = '0; addr_mode = 0; data_mode = 0; seed = '0; base = '0;
    num_cmds = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_a");
    sel = 1; #1;
    check_all_zero("reset_b");
    rst_n = 1;
    @(posedge clk); #1;

    run(0, 2'd0, 2'd0, 32'hA5A5_0000, 21'h0, 16, -1, 0, 0, 0);
    run(0, 2'd0, 2'd0, 32'hA5A5_0000, 21'h0, 16, 5, 0, 0, 0);
    run(0, 2'd1, 2'd1, 32'h1, 21'h0, 8, -1, 0, 0, 0);
    run(0, 2'd0, 2'd0, 32'h1234_5678, 21'h40, 4, -1, 1, 0, 0);
    run(1, 2'd0, 2'd2, 32'h0, 21'h3FC, 2, -1, 0, 0, 0);
    run(0, 2'd2, 2'd0, $urandom, 21'h1_2345, 5, -1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      rb = 21'($urandom);
      run(0, 2'($urandom_range(2)), 2'($urandom_range(2)), $urandom, rb,
          int'($urandom_range(12, 1)), ($urandom_range(1) == 1) ? int'(rb) : -1, 0, 0, 0);
    end
    run(0, 2'd0, 2'd0, 32'hFFFF_0000, 21'h100, 4, -1, 0, 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    run(0, 2'd0, 2'd0, 32'hFFFF_0000, 21'h100, 4, -1, 0, 0, 0);
    run(0, 2'd0, 2'd0, 32'h0, 21'h0, 0, -1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
